ps2_frame_receiver: RTL and testbench
=====================================

// Module: ps2_frame_receiver
// PURPOSE
//   Front-end PS/2 receive stage feeding KEY_CONTROLLER. Samples the raw PS2_CLK/PS2_DAT pins in the clock27
//   domain, deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop), validates them and
//   collapses F0/E0 prefix bytes. Emits one-cycle-strobed scan codes, each tagged with release/extended flags.
//   Replaces direct sampling of the pins on the keyboard clock edge.
// PARAMETERS
//   SYNC_STAGES     2      flip-flop depth of the input synchronisers (min 2)
//   FILTER_LEN      4      consecutive equal synchronised samples needed before the filtered PS/2 clock changes
//   TIMEOUT_CYCLES  54000  clock27 cycles (2 ms) with no filtered falling edge before a partial frame is aborted
// PORTS
//   clock27        in   1  system clock, 27 MHz
//   reset          in   1  synchronous, active-high reset
//   keyboardClock  in   1  raw PS2_CLK pin, asynchronous
//   keyboardData   in   1  raw PS2_DAT pin, asynchronous
//   scanCode       out  8  last accepted make code (prefixes stripped)
//   scanValid      out  1  one-cycle strobe: scanCode/keyRelease/keyExtended are new
//   keyRelease     out  1  scanCode was preceded by F0 (break code)
//   keyExtended    out  1  scanCode was preceded by E0
//   frameError     out  1  one-cycle strobe: bad start/parity/stop, or timeout
//   busy           out  1  high while a frame is in progress (state != IDLE)
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, bit count 0, shift reg 0, prefix flags 0, filter output=1, timer 0.
//     Reset mid-frame discards the partial frame and emits no strobe.
//   Input path: both pins pass through SYNC_STAGES FFs. The filtered clock takes the synchronised value only after
//     FILTER_LEN consecutive identical samples. A fall event is a 1-cycle pulse when the filtered clock goes 1->0.
//     Data is sampled from synchronised PS2_DAT on the fall-event cycle.
//   FSM, advancing only on fall events:
//     IDLE:   data=0 -> DATA, cnt=0; data=1 -> stay IDLE, no error (noise)
//     DATA:   shift data into bit[cnt], LSB first; after the 8th bit -> PARITY
//     PARITY: store bit -> STOP
//     STOP:   -> IDLE; the frame is good iff stop=1 and popcount(data8,parity) is odd
//   Completion, same cycle the FSM returns to IDLE (latency from raw pin edge <= SYNC_STAGES+FILTER_LEN+2 cycles):
//     bad frame           : frameError=1 for one cycle; clear both prefix flags; scanCode unchanged
//     good F0             : set relPend; no scanValid
//     good E0             : set extPend; no scanValid
//     other good byte     : scanCode<=byte, keyRelease<=relPend, keyExtended<=extPend, scanValid=1 for one cycle;
//                           clear both flags
//   keyRelease/keyExtended/scanCode hold until the next scanValid.
//   Timeout: timer clears on every fall event and on IDLE, and counts while not IDLE. When it reaches
//     TIMEOUT_CYCLES-1: -> IDLE, frameError pulse, clear prefix flags. A fall event in the same cycle wins;
//     no timeout that cycle.
//   scanValid and frameError are never high in the same cycle. Back-to-back frames need no idle gap.
// TESTING
//   1 frame 0x1C (start0, data 0,0,1,1,1,0,0,0, parity0, stop1) -> one scanValid, scanCode=1C, keyRelease=0, frameError=0
//   2 frames F0 (parity1) then 1C -> exactly one scanValid, scanCode=1C, keyRelease=1, keyExtended=0;
//     next 0x5A (parity1) -> keyRelease=0
//   3 frames E0, F0, 0x75 -> one scanValid, scanCode=75, keyRelease=1, keyExtended=1
//   4 frame 0x1C with parity=1, then frame 0x1C with stop=0 -> frameError pulse each, no scanValid, scanCode unchanged
//   5 glitch: PS2_CLK low for FILTER_LEN-1 cycles in IDLE, data low -> busy stays 0, no strobes
//   6 start + 5 data bits, then clock idle -> frameError exactly TIMEOUT_CYCLES after last fall, busy=0;
//     next 0x5A frame -> scanValid, scanCode=5A; repeat with reset at bit 4 -> no strobes, busy=0 next cycle

Source files
------------

// File: rtl/ps2_frame_receiver.sv
// PS/2 receive front end: synchronise and deglitch the pins, deserialise 11-bit frames, fold F0/E0 prefixes.
// Latency: strobes appear SYNC_STAGES+FILTER_LEN cycles after the raw PS2_CLK fall that ends a frame.
// Backpressure: none; scanValid/frameError are single-cycle strobes that the consumer must take as they come.
module ps2_frame_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 54000
) (
  input  logic       clock27,
  input  logic       reset,
  input  logic       keyboardClock,
  input  logic       keyboardData,
  output logic [7:0] scanCode,
  output logic       scanValid,
  output logic       keyRelease,
  output logic       keyExtended,
  output logic       frameError,
  output logic       busy
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_filt;
  logic [FW-1:0]          r_filt_cnt;
  logic                   w_clk_s;
  logic                   w_dat_s;
  logic                   w_fall;

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_shift, w_shift_nxt;
  logic        r_par, w_par_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic        r_rel_pend, w_rel_pend_nxt;
  logic        r_ext_pend, w_ext_pend_nxt;
  logic [7:0]  r_scan_code, w_scan_code_nxt;
  logic        r_scan_valid, w_scan_valid_nxt;
  logic        r_key_release, w_key_release_nxt;
  logic        r_key_ext, w_key_ext_nxt;
  logic        r_frame_err, w_frame_err_nxt;
  logic        w_frame_end;
  logic        w_good;
  logic        w_timeout;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  // The filtered clock is about to drop: this is the last of FILTER_LEN low samples.
  assign w_fall  = r_filt && !w_clk_s && (r_filt_cnt == FW'(FILTER_LEN - 1));

  // Synchronise both pins (idle line is high) and debounce the clock.
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_filt     <= 1'b1;
      r_filt_cnt <= '0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], keyboardClock};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], keyboardData};
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  // Frame FSM, prefix tracking and output strobes: next-state and next-output logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_shift_nxt       = r_shift;
    w_par_nxt         = r_par;
    w_frame_end       = 1'b0;
    w_good            = 1'b0;
    w_timeout         = 1'b0;
    w_rel_pend_nxt    = r_rel_pend;
    w_ext_pend_nxt    = r_ext_pend;
    w_scan_code_nxt   = r_scan_code;
    w_key_release_nxt = r_key_release;
    w_key_ext_nxt     = r_key_ext;
    w_scan_valid_nxt  = 1'b0;
    w_frame_err_nxt   = 1'b0;

    if (w_fall) begin
      case (r_state)
        ST_IDLE: begin
          // A high data bit at a clock fall in IDLE is treated as noise.
          if (!w_dat_s) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = 3'd0;
          end
        end
        ST_DATA: begin
          w_shift_nxt[r_cnt] = w_dat_s;
          if (r_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end else begin
            w_cnt_nxt = r_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          w_par_nxt   = w_dat_s;
          w_state_nxt = ST_STOP;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_frame_end = 1'b1;
          w_good      = w_dat_s && (^{r_shift, r_par});
        end
      endcase
    end else if ((r_state != ST_IDLE) && (r_timer == TW'(TIMEOUT_CYCLES - 1))) begin
      w_timeout   = 1'b1;
      w_state_nxt = ST_IDLE;
    end

    // Timer only runs mid-frame and restarts at every clock fall.
    if (w_fall || (r_state == ST_IDLE) || w_timeout) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + TW'(1);
    end

    if ((w_frame_end && !w_good) || w_timeout) begin
      w_frame_err_nxt = 1'b1;
      w_rel_pend_nxt  = 1'b0;
      w_ext_pend_nxt  = 1'b0;
    end else if (w_good) begin
      if (r_shift == 8'hF0) begin
        w_rel_pend_nxt = 1'b1;
      end else if (r_shift == 8'hE0) begin
        w_ext_pend_nxt = 1'b1;
      end else begin
        w_scan_code_nxt   = r_shift;
        w_key_release_nxt = r_rel_pend;
        w_key_ext_nxt     = r_ext_pend;
        w_scan_valid_nxt  = 1'b1;
        w_rel_pend_nxt    = 1'b0;
        w_ext_pend_nxt    = 1'b0;
      end
    end
  end

  // Register FSM state, prefix flags and outputs.
  always_ff @(posedge clock27) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_par         <= 1'b0;
      r_timer       <= '0;
      r_rel_pend    <= 1'b0;
      r_ext_pend    <= 1'b0;
      r_scan_code   <= '0;
      r_scan_valid  <= 1'b0;
      r_key_release <= 1'b0;
      r_key_ext     <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_par         <= w_par_nxt;
      r_timer       <= w_timer_nxt;
      r_rel_pend    <= w_rel_pend_nxt;
      r_ext_pend    <= w_ext_pend_nxt;
      r_scan_code   <= w_scan_code_nxt;
      r_scan_valid  <= w_scan_valid_nxt;
      r_key_release <= w_key_release_nxt;
      r_key_ext     <= w_key_ext_nxt;
      r_frame_err   <= w_frame_err_nxt;
    end
  end

  assign scanCode    = r_scan_code;
  assign scanValid   = r_scan_valid;
  assign keyRelease  = r_key_release;
  assign keyExtended = r_key_ext;
  assign frameError  = r_frame_err;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: frames are bit-banged on the raw pins.
// Strobes are counted by a monitor; results are checked after each step.
// Timeout is shortened so the abort case runs quickly.
module tb_ps2_frame_receiver;

  localparam int S = 2;
  localparam int F = 4;
  localparam int T = 1000;

  logic       clock27 = 1'b0;
  logic       reset = 1'b1;
  logic       keyboardClock = 1'b1;
  logic       keyboardData = 1'b1;
  logic [7:0] scanCode;
  logic       scanValid;
  logic       keyRelease;
  logic       keyExtended;
  logic       frameError;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int n_both  = 0;
  int v0, e0, got, k;
  logic busy_seen;

  ps2_frame_receiver #(.SYNC_STAGES(S), .FILTER_LEN(F), .TIMEOUT_CYCLES(T)) dut (
    .clock27(clock27), .reset(reset), .keyboardClock(keyboardClock), .keyboardData(keyboardData),
    .scanCode(scanCode), .scanValid(scanValid), .keyRelease(keyRelease), .keyExtended(keyExtended),
    .frameError(frameError), .busy(busy)
  );

  always #5 clock27 = ~clock27;

  always @(posedge clock27) begin
    if (!reset) begin
      if (scanValid) n_valid++;
      if (frameError) n_err++;
      if (scanValid && frameError) n_both++;
    end
  end

  task automatic tick();
    @(posedge clock27);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    keyboardData = b;
    repeat (8) tick();
    keyboardClock = 1'b0;
    repeat (8) tick();
    keyboardClock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop);
    keyboardData = 1'b1;
    repeat (4) tick();
  endtask

  task automatic snap();
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    repeat (5) tick();
    chk("rst_code", scanCode, 8'h00);
    chk("rst_valid", scanValid, 0);
    chk("rst_rel", keyRelease, 0);
    chk("rst_ext", keyExtended, 0);
    chk("rst_err", frameError, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    repeat (5) tick();

    // 1: plain make code
    snap();
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t1_nvalid", n_valid - v0, 1);
    chk("t1_nerr", n_err - e0, 0);
    chk("t1_code", scanCode, 8'h1C);
    chk("t1_rel", keyRelease, 0);
    chk("t1_ext", keyExtended, 0);

    // 2: break code, then a fresh make
    snap();
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("t2_f0_novalid", n_valid - v0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t2_nvalid", n_valid - v0, 1);
    chk("t2_code", scanCode, 8'h1C);
    chk("t2_rel", keyRelease, 1);
    chk("t2_ext", keyExtended, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("t2_5a_code", scanCode, 8'h5A);
    chk("t2_5a_rel", keyRelease, 0);

    // 3: extended break
    snap();
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("t3_nvalid", n_valid - v0, 1);
    chk("t3_code", scanCode, 8'h75);
    chk("t3_rel", keyRelease, 1);
    chk("t3_ext", keyExtended, 1);

    // 4: parity error, stop error; a bad frame also drops a pending prefix
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("t4_par_nerr", n_err - e0, 1);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t4_stop_nerr", n_err - e0, 2);
    chk("t4_nvalid", n_valid - v0, 0);
    chk("t4_code", scanCode, 8'h75);
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t4_flag_clr_ext", keyExtended, 0);
    chk("t4_flag_clr_rel", keyRelease, 0);

    // 5: clock glitch one sample short of the filter length
    snap();
    busy_seen = 1'b0;
    keyboardData = 1'b0;
    keyboardClock = 1'b0;
    repeat (F - 1) tick();
    keyboardClock = 1'b1;
    repeat (20) begin
      tick();
      busy_seen = busy_seen | busy;
    end
    keyboardData = 1'b1;
    repeat (4) tick();
    chk("t5_busy", busy_seen, 0);
    chk("t5_nvalid", n_valid - v0, 0);
    chk("t5_nerr", n_err - e0, 0);

    // 6: partial frame times out
    snap();
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    keyboardData = 1'b0;
    repeat (8) tick();
    chk("t6_busy_mid", busy, 1);
    keyboardClock = 1'b0;
    got = 0;
    k = 0;
    while (k < S + F + T + 50 && got == 0) begin
      tick();
      k++;
      if (k == 8) keyboardClock = 1'b1;
      if (frameError) got = k;
    end
    chk("t6_timeout_lat", got, S + F + T);
    chk("t6_busy_after", busy, 0);
    keyboardData = 1'b1;
    repeat (4) tick();
    chk("t6_nerr", n_err - e0, 1);
    chk("t6_nvalid", n_valid - v0, 0);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk("t6_5a_nvalid", n_valid - v0, 1);
    chk("t6_5a_code", scanCode, 8'h5A);

    // 6b: reset mid-frame
    snap();
    send_bit(1'b0);
    repeat (3) send_bit(1'b1);
    keyboardData = 1'b0;
    repeat (8) tick();
    keyboardClock = 1'b0;
    repeat (8) tick();
    chk("t6r_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    chk("t6r_busy", busy, 0);
    chk("t6r_code", scanCode, 8'h00);
    keyboardClock = 1'b1;
    keyboardData = 1'b1;
    reset = 1'b0;
    repeat (1200) tick();
    chk("t6r_nvalid", n_valid - v0, 0);
    chk("t6r_nerr", n_err - e0, 0);
    chk("t6r_busy_end", busy, 0);

    chk("never_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
